// File: rtl/regxfer_seq.sv
// rtl/regxfer_seq.sv - register-transfer sequencer driving the regfile select/data ports
// Handles one LDI/MOV/ALUWB/SWAP instruction at a time through a small multi-cycle FSM.
module regxfer_seq #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [1:0]            instr_op,
  input  logic [ADDR_WIDTH-1:0] instr_rd,
  input  logic [ADDR_WIDTH-1:0] instr_rs,
  input  logic [ADDR_WIDTH-1:0] instr_rt,
  input  logic [DATA_WIDTH-1:0] instr_imm,
  input  logic [DATA_WIDTH-1:0] sbus_out,
  input  logic [DATA_WIDTH-1:0] alu_result,
  output logic [DATA_WIDTH-1:0] sbus_in,
  output logic [ADDR_WIDTH-1:0] write_select,
  output logic [ADDR_WIDTH-1:0] sbus_select,
  output logic [ADDR_WIDTH-1:0] alu_select,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {IDLE, RD1, RD2, WR1, WR2} state_t;

  localparam logic [1:0] OP_LDI   = 2'b00;
  localparam logic [1:0] OP_ALUWB = 2'b10;
  localparam logic [1:0] OP_SWAP  = 2'b11;

  state_t                state;
  logic [1:0]            op_q;
  logic [ADDR_WIDTH-1:0] rd_q, rs_q;
  logic [DATA_WIDTH-1:0] tmp_a, tmp_b;
  logic [ADDR_WIDTH-1:0] ws_q, ss_q, as_q;
  logic [DATA_WIDTH-1:0] sin_q;
  logic                  done_q;

  // A write to R0 is a dead cycle: no address and no data on the write port.
  function automatic logic [DATA_WIDTH-1:0] wdata(input logic [ADDR_WIDTH-1:0] a,
                                                  input logic [DATA_WIDTH-1:0] d);
    return (a != '0) ? d : '0;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      op_q   <= '0;
      rd_q   <= '0;
      rs_q   <= '0;
      tmp_a  <= '0;
      tmp_b  <= '0;
      ws_q   <= '0;
      ss_q   <= '0;
      as_q   <= '0;
      sin_q  <= '0;
      done_q <= 1'b0;
    end else begin
      ws_q   <= '0;
      sin_q  <= '0;
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (instr_valid) begin
            op_q <= instr_op;
            rd_q <= instr_rd;
            rs_q <= instr_rs;
            ss_q <= instr_rs;
            if (instr_op == OP_ALUWB) as_q <= instr_rt;
            if (instr_op == OP_LDI) begin
              state  <= WR1;
              ws_q   <= instr_rd;
              sin_q  <= wdata(instr_rd, instr_imm);
              done_q <= 1'b1;
            end else begin
              state <= RD1;
            end
          end
        end
        RD1: begin
          if (op_q == OP_SWAP) begin
            tmp_a <= sbus_out;
            ss_q  <= rd_q;
            state <= RD2;
          end else begin
            tmp_a  <= (op_q == OP_ALUWB) ? alu_result : sbus_out;
            ws_q   <= rd_q;
            sin_q  <= wdata(rd_q, (op_q == OP_ALUWB) ? alu_result : sbus_out);
            done_q <= 1'b1;
            state  <= WR1;
          end
        end
        RD2: begin
          tmp_b <= sbus_out;
          ws_q  <= rd_q;
          sin_q <= wdata(rd_q, tmp_a);
          state <= WR1;
        end
        WR1: begin
          if (op_q == OP_SWAP) begin
            ws_q   <= rs_q;
            sin_q  <= wdata(rs_q, tmp_b);
            done_q <= 1'b1;
            state  <= WR2;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Masking with rst drops a write already on the port when reset lands mid-op.
  assign instr_ready  = (state == IDLE) && !rst;
  assign busy         = (state != IDLE) && !rst;
  assign done         = done_q && !rst;
  assign write_select = rst ? '0 : ws_q;
  assign sbus_in      = rst ? '0 : sin_q;
  assign sbus_select  = rst ? '0 : ss_q;
  assign alu_select   = rst ? '0 : as_q;

endmodule

// File: tb/tb_regxfer_seq.sv
// tb/tb_regxfer_seq.sv - scoreboard bench for regxfer_seq with a behavioural regfile and adder ALU
module tb_regxfer_seq;

  localparam logic [1:0] LDI = 2'b00, MOV = 2'b01, ALUWB = 2'b10, SWAP = 2'b11;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [1:0]  instr_op = '0;
  logic [4:0]  instr_rd = '0, instr_rs = '0, instr_rt = '0;
  logic [31:0] instr_imm = '0;
  logic [31:0] sbus_out, alu_result, sbus_in;
  logic [4:0]  write_select, sbus_select, alu_select;
  logic        busy, done;

  logic [31:0] regs [32];
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;
  wr_t exp_q[$];
  wr_t mon_e;

  regxfer_seq #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs(instr_rs),
    .instr_rt(instr_rt), .instr_imm(instr_imm),
    .sbus_out(sbus_out), .alu_result(alu_result), .sbus_in(sbus_in),
    .write_select(write_select), .sbus_select(sbus_select),
    .alu_select(alu_select), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // R0 is stored like any other register so a stray write to it is visible.
  assign sbus_out   = regs[sbus_select];
  assign alu_result = regs[sbus_select] + regs[alu_select];

  always @(posedge clk)
    if (write_select != 5'd0) regs[write_select] <= sbus_in;

  always @(negedge clk) begin
    if (!rst && write_select != 5'd0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write actual addr=%0d data=%h required none", write_select, sbus_in);
      end else begin
        mon_e = exp_q.pop_front();
        if (write_select !== mon_e.addr || sbus_in !== mon_e.data) begin
          errors++;
          $display("FAIL write actual addr=%0d data=%h required addr=%0d data=%h",
                   write_select, sbus_in, mon_e.addr, mon_e.data);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic push(input logic [4:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic [1:0] op, input logic [4:0] rd, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [31:0] imm);
    instr_valid = 1'b1;
    instr_op    = op;
    instr_rd    = rd;
    instr_rs    = rs;
    instr_rt    = rt;
    instr_imm   = imm;
  endtask

  task automatic send(input logic [1:0] op, input logic [4:0] rd, input logic [4:0] rs,
                      input logic [4:0] rt, input logic [31:0] imm, input int exp_cyc);
    int n;
    n = 0;
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_issue", {31'd0, instr_ready}, 32'd1);
    drive(op, rd, rs, rt, imm);
    @(negedge clk);
    instr_valid = 1'b0;
    chk("busy_first_cycle", {31'd0, busy}, 32'd1);
    if (op != LDI) chk("sbus_select_rd1", {27'd0, sbus_select}, {27'd0, rs});
    if (op == ALUWB) chk("alu_select_rd1", {27'd0, alu_select}, {27'd0, rt});
    n = 1;
    while (!done && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("latency", n, exp_cyc);
    @(negedge clk);
    chk("idle_after_done", {29'd0, busy, done, instr_ready}, 32'd1);
  endtask

  initial begin
    int acc;
    for (int i = 0; i < 32; i++) regs[i] = '0;

    @(negedge clk);
    chk("rst_ready", {31'd0, instr_ready}, 32'd0);
    chk("rst_outputs", {write_select, sbus_select, alu_select, busy, done}, 32'd0);
    chk("rst_sbus_in", sbus_in, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    push(5'd5, 32'hDEADBEEF);
    send(LDI, 5'd5, 5'd0, 5'd0, 32'hDEADBEEF, 1);
    chk("r5", regs[5], 32'hDEADBEEF);

    push(5'd7, 32'hDEADBEEF);
    send(MOV, 5'd7, 5'd5, 5'd0, 32'h0, 2);
    chk("r7", regs[7], 32'hDEADBEEF);

    push(5'd1, 32'h12345678);
    send(LDI, 5'd1, 5'd0, 5'd0, 32'h12345678, 1);
    push(5'd2, 32'h0000FFFF);
    send(LDI, 5'd2, 5'd0, 5'd0, 32'h0000FFFF, 1);
    push(5'd1, 32'h0000FFFF);
    push(5'd2, 32'h12345678);
    send(SWAP, 5'd1, 5'd2, 5'd0, 32'h0, 4);
    chk("swap_r1", regs[1], 32'h0000FFFF);
    chk("swap_r2", regs[2], 32'h12345678);

    send(LDI, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFF, 1);
    chk("r0_untouched", regs[0], 32'h0);

    // SWAP r1,r2 with reset landing while the WR1 write is on the port.
    drive(SWAP, 5'd1, 5'd2, 5'd0, 32'h0);
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    chk("wr1_reached", {27'd0, write_select}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_write_select", {27'd0, write_select}, 32'd0);
    chk("midrst_flags", {29'd0, busy, done, instr_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("postrst_selects", {22'd0, sbus_select, alu_select}, 32'd0);
    chk("postrst_busy", {31'd0, busy}, 32'd0);
    chk("postrst_r1", regs[1], 32'h0000FFFF);
    chk("postrst_r2", regs[2], 32'h12345678);

    // MOV held valid for 10 cycles: accepts at cycles 0,3,6,9.
    while (!instr_ready) @(negedge clk);
    for (int i = 0; i < 4; i++) push(5'd7, 32'hDEADBEEF);
    drive(MOV, 5'd7, 5'd5, 5'd0, 32'h0);
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      if (instr_ready) acc++;
      @(negedge clk);
    end
    instr_valid = 1'b0;
    chk("held_valid_accepts", acc, 32'd4);
    repeat (3) @(negedge clk);

    push(5'd3, 32'h12355677);
    send(ALUWB, 5'd3, 5'd1, 5'd2, 32'h0, 2);
    chk("aluwb_r3", regs[3], 32'h12355677);

    push(5'd4, 32'hA5A5A5A5);
    send(LDI, 5'd4, 5'd0, 5'd0, 32'hA5A5A5A5, 1);
    push(5'd4, 32'hA5A5A5A5);
    push(5'd4, 32'hA5A5A5A5);
    send(SWAP, 5'd4, 5'd4, 5'd0, 32'h0, 4);
    chk("swap_same_r4", regs[4], 32'hA5A5A5A5);

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
